// File: rtl/sar_adc_ctrl_if.sv
// Handshake and analog-front-end signals of the SAR ADC controller.
// The slave modport is the controller; the master side is the fabric/front end.
interface sar_adc_ctrl_if #(
  parameter int N_BITS = 8
);
  logic              start_i;
  logic              cmp_i;
  logic              sample_o;
  logic [N_BITS-1:0] dac_code_o;
  logic              cmp_latch_o;
  logic              busy_o;
  logic              valid_o;
  logic [N_BITS-1:0] data_o;

  modport master (
    output start_i, cmp_i,
    input  sample_o, dac_code_o, cmp_latch_o, busy_o, valid_o, data_o
  );

  modport slave (
    input  start_i, cmp_i,
    output sample_o, dac_code_o, cmp_latch_o, busy_o, valid_o, data_o
  );
endinterface

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: track/hold, per-bit DAC trial with settle
// time, comparator strobe, and a start/busy/valid result handshake.
module sar_adc_ctrl #(
  parameter int N_BITS        = 8,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input logic           clk_i,
  input logic           rst_ni,
  sar_adc_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SAMPLE = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_DECIDE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam int K_W     = $clog2(N_BITS);

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [K_W-1:0]    bit_idx;
  logic [N_BITS-1:0] sar;
  logic [N_BITS-1:0] data_q;

  // The sar register doubles as the DAC code: it is zero outside a conversion
  // and holds the final code during DONE.
  assign bus.sample_o    = (state == S_SAMPLE);
  assign bus.cmp_latch_o = (state == S_DECIDE);
  assign bus.busy_o      = (state != S_IDLE);
  assign bus.valid_o     = (state == S_DONE);
  assign bus.dac_code_o  = sar;
  assign bus.data_o      = data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sar     <= '0;
      data_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start_i) begin
            state <= S_SAMPLE;
            cnt   <= CNT_W'(SAMPLE_CYCLES - 1);
          end
        end
        S_SAMPLE: begin
          if (cnt == '0) begin
            state   <= S_SETTLE;
            cnt     <= CNT_W'(SETTLE_CYCLES - 1);
            bit_idx <= K_W'(N_BITS - 1);
            sar     <= {1'b1, {(N_BITS-1){1'b0}}};
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_SETTLE: begin
          if (cnt == '0) begin
            state <= S_DECIDE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        // Keep or clear the bit under trial, then either arm the next lower
        // bit or publish the whole code at once.
        S_DECIDE: begin
          sar[bit_idx] <= bus.cmp_i;
          if (bit_idx != '0) begin
            sar[bit_idx - 1'b1] <= 1'b1;
            bit_idx             <= bit_idx - 1'b1;
            cnt                 <= CNT_W'(SETTLE_CYCLES - 1);
            state               <= S_SETTLE;
          end else begin
            data_q <= {sar[N_BITS-1:1], bus.cmp_i};
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          sar   <= '0;
        end
        default: begin
          state <= S_IDLE;
          sar   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Self-checking bench for sar_adc_ctrl: an ideal comparator against a held input
// voltage, checked against a binary-search reference model of the conversion.
module tb_sar_adc_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] vin;
  logic [3:0] vin4;
  logic glitch_en;
  logic glitch_val = 1'b0;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  sar_adc_ctrl_if #(.N_BITS(8)) bus ();
  sar_adc_ctrl_if #(.N_BITS(4)) bus4 ();

  // Ideal comparator; optionally scrambled whenever the controller is not strobing it.
  assign bus.cmp_i  = (glitch_en && !bus.cmp_latch_o) ? glitch_val : (vin >= bus.dac_code_o);
  assign bus4.cmp_i = (vin4 >= bus4.dac_code_o);

  always @(posedge clk) begin
    #2;
    glitch_val = 1'($urandom_range(0, 1));
  end

  sar_adc_ctrl #(.N_BITS(8), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(2)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  sar_adc_ctrl #(.N_BITS(4), .SAMPLE_CYCLES(1), .SETTLE_CYCLES(1)) dut4 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus4)
  );

  // Reference model: binary search of v; returns the idx-th trial code.
  function automatic int model_trial(int v, int nb, int idx);
    int code = 0;
    int t = 0;
    for (int b = nb - 1; b >= nb - 1 - idx; b--) begin
      t = code | (1 << b);
      if (v >= t) code = t;
    end
    return t;
  endfunction

  function automatic int model_result(int v, int nb);
    int code = 0;
    for (int b = nb - 1; b >= 0; b--) begin
      if (v >= (code | (1 << b))) code = code | (1 << b);
    end
    return code;
  endfunction

  function automatic int model_latency(int s, int t, int nb);
    return s + nb * (t + 1);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start_i = 1'b0;
    bus4.start_i = 1'b0;
    vin = 8'h00;
    vin4 = 4'h0;
    glitch_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.sample_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_sample: got %b expected 0", bus.sample_o); end
    checks++; if (bus.dac_code_o !== 8'h00) begin fails++; $display("[TB] FAIL reset_dac: got %h expected 00", bus.dac_code_o); end
    checks++; if (bus.cmp_latch_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_latch: got %b expected 0", bus.cmp_latch_o); end
    checks++; if (bus.busy_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy_o); end
    checks++; if (bus.valid_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.valid_o); end
    checks++; if (bus.data_o !== 8'h00) begin fails++; $display("[TB] FAIL reset_data: got %h expected 00", bus.data_o); end
    // start already high when reset lifts: accepted at the very first edge
    bus.start_i = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    checks++; if (bus.busy_o !== 1'b1 || bus.sample_o !== 1'b1) begin fails++; $display("[TB] FAIL first_edge_accept: got busy=%b sample=%b expected 1/1", bus.busy_o, bus.sample_o); end
    repeat (32) @(negedge clk);
  endtask

  task automatic run_one(input logic [7:0] v, input string name);
    int valid_cnt = 0, valid_at = -1, latch_cnt = 0, busy_cnt = 0;
    int sample_cnt = 0, settle_cnt = 0, early = 0;
    int lat;
    logic [7:0] got = 8'h00;
    logic [7:0] prev;
    logic [7:0] exp_code;
    vin = v;
    lat = model_latency(4, 2, 8);
    exp_code = 8'(model_result(v, 8));
    @(negedge clk);
    prev = bus.data_o;
    bus.start_i = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      if (j == 0) bus.start_i = 1'b0;
      if (bus.sample_o) sample_cnt++;
      if (bus.busy_o) busy_cnt++;
      if (bus.busy_o && !bus.sample_o && !bus.cmp_latch_o && !bus.valid_o) settle_cnt++;
      if (j < lat && bus.data_o !== prev) early++;
      if (bus.cmp_latch_o) begin
        if (latch_cnt < 8) begin
          checks++;
          if (bus.dac_code_o !== 8'(model_trial(v, 8, latch_cnt))) begin
            fails++;
            $display("[TB] FAIL %s trial%0d: got %h expected %h", name, latch_cnt, bus.dac_code_o, 8'(model_trial(v, 8, latch_cnt)));
          end
        end
        latch_cnt++;
      end
      if (bus.valid_o) begin valid_cnt++; valid_at = j; got = bus.data_o; end
    end
    checks++; if (valid_cnt != 1) begin fails++; $display("[TB] FAIL %s valid_count: got %0d expected 1", name, valid_cnt); end
    checks++; if (valid_at != lat) begin fails++; $display("[TB] FAIL %s valid_cycle: got %0d expected %0d", name, valid_at, lat); end
    checks++; if (got !== exp_code) begin fails++; $display("[TB] FAIL %s data: got %h expected %h", name, got, exp_code); end
    checks++; if (latch_cnt != 8) begin fails++; $display("[TB] FAIL %s latch_count: got %0d expected 8", name, latch_cnt); end
    checks++; if (busy_cnt != lat + 1) begin fails++; $display("[TB] FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, lat + 1); end
    checks++; if (sample_cnt != 4) begin fails++; $display("[TB] FAIL %s sample_cycles: got %0d expected 4", name, sample_cnt); end
    checks++; if (settle_cnt != 16) begin fails++; $display("[TB] FAIL %s settle_cycles: got %0d expected 16", name, settle_cnt); end
    checks++; if (early != 0) begin fails++; $display("[TB] FAIL %s data_early_change: got %0d expected 0", name, early); end
    checks++; if (bus.data_o !== exp_code || bus.dac_code_o !== 8'h00) begin fails++; $display("[TB] FAIL %s idle_hold: got data=%h dac=%h expected %h/00", name, bus.data_o, bus.dac_code_o, exp_code); end
  endtask

  task automatic test_basic();
    run_one(8'hA5, "vin_a5");
  endtask

  task automatic test_boundaries();
    run_one(8'h00, "vin_00");
    run_one(8'hFF, "vin_ff");
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) run_one(8'($urandom_range(0, 255)), "vin_random");
  endtask

  task automatic test_glitch();
    glitch_en = 1'b1;
    run_one(8'h81, "glitch_81");
    glitch_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    int at_q[$];
    logic [7:0] d_q[$];
    int lat;
    lat = model_latency(4, 2, 8);
    vin = 8'h3C;
    @(negedge clk);
    bus.start_i = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 96; j++) begin
      @(negedge clk);
      if (bus.valid_o) begin at_q.push_back(j); d_q.push_back(bus.data_o); end
    end
    bus.start_i = 1'b0;
    checks++; if (at_q.size() != 3) begin fails++; $display("[TB] FAIL b2b_valid_count: got %0d expected 3", at_q.size()); end
    for (int i = 0; i < at_q.size() && i < 3; i++) begin
      checks++; if (at_q[i] != lat + i * (lat + 2)) begin fails++; $display("[TB] FAIL b2b_valid_cycle%0d: got %0d expected %0d", i, at_q[i], lat + i * (lat + 2)); end
      checks++; if (d_q[i] !== 8'h3C) begin fails++; $display("[TB] FAIL b2b_data%0d: got %h expected 3c", i, d_q[i]); end
    end
    repeat (32) @(negedge clk);
  endtask

  task automatic test_reset_midconv();
    int valid_seen = 0;
    vin = 8'h77;
    @(negedge clk);
    bus.start_i = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (j == 0) bus.start_i = 1'b0;
      if (bus.valid_o) valid_seen++;
    end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (valid_seen != 0) begin fails++; $display("[TB] FAIL midrst_valid_before: got %0d expected 0", valid_seen); end
    checks++;
    if ({bus.sample_o, bus.cmp_latch_o, bus.busy_o, bus.valid_o} !== 4'b0000 || bus.dac_code_o !== 8'h00 || bus.data_o !== 8'h00) begin
      fails++;
      $display("[TB] FAIL midrst_outputs: got s=%b l=%b b=%b v=%b dac=%h data=%h expected all 0", bus.sample_o, bus.cmp_latch_o, bus.busy_o, bus.valid_o, bus.dac_code_o, bus.data_o);
    end
    repeat (2) @(negedge clk);
    checks++; if (bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin fails++; $display("[TB] FAIL midrst_held: got busy=%b valid=%b expected 0/0", bus.busy_o, bus.valid_o); end
    rst_n = 1'b1;
    run_one(8'h5A, "after_reset_5a");
  endtask

  task automatic test_param_sweep();
    logic [3:0] vals [3];
    vals[0] = 4'h9;
    vals[1] = 4'($urandom_range(0, 15));
    vals[2] = 4'($urandom_range(0, 15));
    for (int i = 0; i < 3; i++) begin
      int valid_cnt = 0, valid_at = -1, lat;
      logic [3:0] got = 4'h0;
      lat = model_latency(1, 1, 4);
      vin4 = vals[i];
      @(negedge clk);
      bus4.start_i = 1'b1;
      @(posedge clk);
      for (int j = 0; j < 14; j++) begin
        @(negedge clk);
        if (j == 0) bus4.start_i = 1'b0;
        if (bus4.valid_o) begin valid_cnt++; valid_at = j; got = bus4.data_o; end
      end
      checks++; if (valid_cnt != 1 || valid_at != lat) begin fails++; $display("[TB] FAIL sweep_valid: got count=%0d cycle=%0d expected 1/%0d", valid_cnt, valid_at, lat); end
      checks++; if (got !== 4'(model_result(vals[i], 4))) begin fails++; $display("[TB] FAIL sweep_data: got %h expected %h", got, 4'(model_result(vals[i], 4))); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_random();
    test_glitch();
    test_back_to_back();
    test_reset_midconv();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
